// File: rtl/jt12_mix_n.sv
// Serial stereo mixer: NUM_SRC sources, per-source gain, saturated output.
// Optional DC blocker after saturation when JT12_MIX_DCBLOCK_EN is defined.
module jt12_mix_n #(
    parameter int NUM_SRC = 4,
    parameter int IN_W    = 16,
    parameter int OUT_W   = 16,
    parameter int GAIN_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cen,
    input  logic [NUM_SRC*IN_W-1:0]   src_left,
    input  logic [NUM_SRC*IN_W-1:0]   src_right,
    input  logic                      sample_in,
    input  logic                      gain_wr,
    input  logic [2:0]                gain_addr,
    input  logic [GAIN_W-1:0]         gain_din,
    output logic                      busy,
    output logic                      overrun,
    input  logic                      ovr_clr,
    output logic signed [OUT_W-1:0]   snd_left,
    output logic signed [OUT_W-1:0]   snd_right,
    output logic                      snd_sample
);

    localparam int IW = $clog2(NUM_SRC);
    localparam int PW = IN_W + GAIN_W + 1;
    localparam int AW = IN_W + GAIN_W + IW + 1;
    localparam int SH = GAIN_W - 2;
    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(2 ** SH);
    localparam logic [IW-1:0] LAST = IW'(NUM_SRC - 1);

    typedef enum logic [1:0] {IDLE, ACC, SAT, DCB} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic signed [AW-1:0]    accl_q, accl_d;
    logic signed [AW-1:0]    accr_q, accr_d;
    logic signed [IN_W-1:0]  srcl_q [NUM_SRC];
    logic signed [IN_W-1:0]  srcr_q [NUM_SRC];
    logic [GAIN_W-1:0]       gain_q [NUM_SRC];
    logic [GAIN_W-1:0]       gsh_q  [NUM_SRC];
    logic signed [OUT_W-1:0] snd_left_q, snd_right_q;
    logic signed [OUT_W-1:0] outl_d, outr_d;
    logic                    snd_sample_q;
    logic                    ovr_q;
    logic                    start, load;
    logic signed [PW-1:0]    prodl, prodr;

    function automatic logic signed [OUT_W-1:0] sat_acc(
        input logic signed [AW-1:0] a
    );
        logic signed [AW-1:0] s;
        logic [AW-OUT_W:0]    hi;
        s  = a >>> SH;
        hi = s[AW-1:OUT_W-1];
        if (&hi || ~|hi) return s[OUT_W-1:0];
        else if (s[AW-1]) return {1'b1, {(OUT_W-1){1'b0}}};
        else return {1'b0, {(OUT_W-1){1'b1}}};
    endfunction

    // Signed sample times unsigned gain: zero-extend the gain first.
    assign prodl = PW'(srcl_q[idx_q]) * PW'($signed({1'b0, gsh_q[idx_q]}));
    assign prodr = PW'(srcr_q[idx_q]) * PW'($signed({1'b0, gsh_q[idx_q]}));

`ifdef JT12_MIX_DCBLOCK_EN
    localparam int DW = OUT_W + 10;

    logic signed [OUT_W-1:0] xl_q, xr_q, xpl_q, xpr_q;

    function automatic logic signed [OUT_W-1:0] dc_step(
        input logic signed [OUT_W-1:0] x,
        input logic signed [OUT_W-1:0] xp,
        input logic signed [OUT_W-1:0] yp
    );
        logic signed [DW-1:0] y;
        logic [DW-OUT_W:0]    hi;
        y  = DW'(x) - DW'(xp) + DW'(yp) - (DW'(yp) >>> 8);
        hi = y[DW-1:OUT_W-1];
        if (&hi || ~|hi) return y[OUT_W-1:0];
        else if (y[DW-1]) return {1'b1, {(OUT_W-1){1'b0}}};
        else return {1'b0, {(OUT_W-1){1'b1}}};
    endfunction

    // The output register doubles as the y[n-1] history.
    assign outl_d = dc_step(xl_q, xpl_q, snd_left_q);
    assign outr_d = dc_step(xr_q, xpr_q, snd_right_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xl_q  <= '0;
            xr_q  <= '0;
            xpl_q <= '0;
            xpr_q <= '0;
        end else begin
            if (cen && state_q == SAT) begin
                xl_q <= sat_acc(accl_q);
                xr_q <= sat_acc(accr_q);
            end
            if (load) begin
                xpl_q <= xl_q;
                xpr_q <= xr_q;
            end
        end
    end
`else
    assign outl_d = sat_acc(accl_q);
    assign outr_d = sat_acc(accr_q);
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        accl_d  = accl_q;
        accr_d  = accr_q;
        start   = 1'b0;
        load    = 1'b0;
        if (cen) begin
            unique case (state_q)
                IDLE: begin
                    if (sample_in) begin
                        start   = 1'b1;
                        accl_d  = '0;
                        accr_d  = '0;
                        idx_d   = '0;
                        state_d = ACC;
                    end
                end
                ACC: begin
                    accl_d = accl_q + AW'(prodl);
                    accr_d = accr_q + AW'(prodr);
                    if (idx_q == LAST) state_d = SAT;
                    else idx_d = idx_q + IW'(1);
                end
                SAT: begin
`ifdef JT12_MIX_DCBLOCK_EN
                    state_d = DCB;
`else
                    load    = 1'b1;
                    state_d = IDLE;
`endif
                end
                default: begin
`ifdef JT12_MIX_DCBLOCK_EN
                    load = 1'b1;
`endif
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            accl_q       <= '0;
            accr_q       <= '0;
            snd_left_q   <= '0;
            snd_right_q  <= '0;
            snd_sample_q <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            accl_q       <= accl_d;
            accr_q       <= accr_d;
            snd_sample_q <= load;
            if (load) begin
                snd_left_q  <= outl_d;
                snd_right_q <= outr_d;
            end
            // A dropped sample takes priority over a clear.
            if (cen && sample_in && state_q != IDLE) ovr_q <= 1'b1;
            else if (ovr_clr) ovr_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                gain_q[k] <= UNITY;
                gsh_q[k]  <= UNITY;
                srcl_q[k] <= '0;
                srcr_q[k] <= '0;
            end
        end else begin
            if (gain_wr && (int'(gain_addr) < NUM_SRC))
                gain_q[gain_addr[IW-1:0]] <= gain_din;
            if (start) begin
                for (int k = 0; k < NUM_SRC; k++) begin
                    srcl_q[k] <= src_left[k*IN_W +: IN_W];
                    srcr_q[k] <= src_right[k*IN_W +: IN_W];
                    gsh_q[k]  <= gain_q[k];
                end
            end
        end
    end

    assign busy       = (state_q != IDLE);
    assign overrun    = ovr_q;
    assign snd_left   = snd_left_q;
    assign snd_right  = snd_right_q;
    assign snd_sample = snd_sample_q;

endmodule

// File: tb/tb_jt12_mix_n.sv
// Bench for jt12_mix_n: vector table plus corner-case sequences,
// checked through a queue scoreboard drained on snd_sample.
`timescale 1ns/1ps
module tb_jt12_mix_n;

    localparam int N  = 4;
    localparam int IW = 16;
    localparam int OW = 16;
    localparam int GW = 8;

    typedef int i4_t [4];
    typedef struct {
        int l0, l1, l2, l3;
        int r0, r1, r2, r3;
        int g0, g1, g2, g3;
        int el, er;
    } vec_t;
    typedef struct {
        int el;
        int er;
        int acc;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n, cen, sample_in, gain_wr, ovr_clr;
    logic [N*IW-1:0]      src_left, src_right;
    logic [2:0]           gain_addr;
    logic [GW-1:0]        gain_din;
    logic                 busy, overrun, snd_sample;
    logic signed [OW-1:0] snd_left, snd_right;

    int   checks = 0;
    int   errors = 0;
    int   cen_cnt = 0;
    int   mode = 0;
    int   ph = 0;
    exp_t sb[$];
    i4_t  gm;
    vec_t vt [8];

    jt12_mix_n #(
        .NUM_SRC(N), .IN_W(IW), .OUT_W(OW), .GAIN_W(GW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .src_left(src_left), .src_right(src_right),
        .sample_in(sample_in), .gain_wr(gain_wr),
        .gain_addr(gain_addr), .gain_din(gain_din),
        .busy(busy), .overrun(overrun), .ovr_clr(ovr_clr),
        .snd_left(snd_left), .snd_right(snd_right),
        .snd_sample(snd_sample)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        if (cen === 1'b1) cen_cnt++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (mode == 0) cen = 1'b1;
        else begin
            cen = (ph == 0);
            ph  = (ph == 2) ? 0 : ph + 1;
        end
    end

    task automatic chk(input string n, input longint a, input longint e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1 && snd_sample === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got 1 expected 0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("snd_left", snd_left, e.el);
                chk("snd_right", snd_right, e.er);
                chk("latency", cen_cnt - e.acc + 1, N + 2);
            end
        end
    end

    function automatic int mixm(input i4_t s, input i4_t g);
        longint a;
        a = 0;
        for (int i = 0; i < N; i++) a += longint'(s[i]) * longint'(g[i]);
        a = a >>> (GW - 2);
        if (a > 32767) a = 32767;
        else if (a < -32768) a = -32768;
        return int'(a);
    endfunction

    task automatic drive(input i4_t l, input i4_t r);
        for (int i = 0; i < N; i++) begin
            src_left[i*IW +: IW]  = IW'(l[i]);
            src_right[i*IW +: IW] = IW'(r[i]);
        end
    endtask

    task automatic send(input i4_t l, input i4_t r, input int el, input int er);
        exp_t e;
        drive(l, r);
        sample_in = 1'b1;
        do @(posedge clk); while (cen !== 1'b1);
        #1;
        sample_in = 1'b0;
        e.el  = el;
        e.er  = er;
        e.acc = cen_cnt;
        sb.push_back(e);
    endtask

    task automatic wg(input int a, input int d);
        gain_wr   = 1'b1;
        gain_addr = 3'(a);
        gain_din  = GW'(d);
        @(posedge clk);
        #1;
        gain_wr = 1'b0;
        if (a < N) gm[a] = d;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        i4_t l, r, l0, r0, lx;
        rst_n = 1'b0; cen = 1'b1; sample_in = 1'b0; gain_wr = 1'b0;
        gain_addr = '0; gain_din = '0; ovr_clr = 1'b0;
        src_left = '0; src_right = '0;
        gm = '{64, 64, 64, 64};
        l0 = '{1000, 2000, -500, 0};
        r0 = '{100, -200, 300, -400};

        vt[0] = '{1000, 2000, -500, 0, 100, -200, 300, -400,
                  64, 64, 64, 64, 2500, -200};
        vt[1] = '{20000, 20000, 20000, 20000, -20000, -20000, -20000, -20000,
                  64, 64, 64, 64, 32767, -32768};
        vt[2] = '{0, 2000, 0, 7000, 0, -3, 0, 0,
                  64, 32, 64, 0, 1000, -2};
        vt[3] = '{-32768, 32767, -32768, 1, 100, -100, 6400, -64,
                  128, 255, 1, 64, 32767, -163};
        vt[4] = '{-1, 0, 0, 0, 32767, 0, 0, 0,
                  64, 64, 64, 64, -1, 32767};
        vt[5] = '{32767, 32767, 32767, 32767, -32768, -32768, -32768, -32768,
                  255, 255, 255, 255, 32767, -32768};
        vt[6] = '{32767, 1, 0, 0, -32768, -1, 0, 0,
                  64, 64, 64, 64, 32767, -32768};
        vt[7] = '{100, 200, 300, 400, -100, -200, -300, -400,
                  1, 2, 3, 4, 46, -47};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_left", snd_left, 0);
        chk("rst_right", snd_right, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_sample", snd_sample, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 8; v++) begin
            i4_t g;
            l = '{vt[v].l0, vt[v].l1, vt[v].l2, vt[v].l3};
            r = '{vt[v].r0, vt[v].r1, vt[v].r2, vt[v].r3};
            g = '{vt[v].g0, vt[v].g1, vt[v].g2, vt[v].g3};
            for (int i = 0; i < N; i++) begin
                wg(i, g[i]);
                wg(N + i, 0);
            end
            send(l, r, vt[v].el, vt[v].er);
            wait_idle();
            chk("busy_after", busy, 0);
            chk("pulse_end", snd_sample, 0);
        end

        mode = 1;
        for (int i = 0; i < N; i++) wg(i, 64);
        send(l0, r0, mixm(l0, gm), mixm(r0, gm));
        wait_idle();
        chk("cen3_left", snd_left, 2500);

        l = '{1000, 1000, 1000, 1000};
        r = '{-1000, -1000, -1000, -1000};
        send(l, r, mixm(l, gm), mixm(r, gm));
        wg(2, 0);
        wait_idle();
        chk("shadow_old", snd_left, 4000);
        send(l, r, mixm(l, gm), mixm(r, gm));
        wait_idle();
        chk("shadow_new", snd_left, 3000);

        mode = 0;
        wg(2, 64);
        send(l0, r0, mixm(l0, gm), mixm(r0, gm));
        @(posedge clk);
        #1;
        lx = '{9, 9, 9, 9};
        drive(lx, lx);
        sample_in = 1'b1;
        @(posedge clk);
        #1;
        sample_in = 1'b0;
        wait_idle();
        chk("ovr_set", overrun, 1);
        chk("ovr_keep_first", snd_left, 2500);
        ovr_clr = 1'b1;
        @(posedge clk);
        #1;
        ovr_clr = 1'b0;
        chk("ovr_clr", overrun, 0);

        l = '{10, 20, 30, 40};
        r = '{-10, -20, -30, -40};
        send(l, r, mixm(l, gm), mixm(r, gm));
        sample_in = 1'b1;
        ovr_clr   = 1'b1;
        @(posedge clk);
        #1;
        sample_in = 1'b0;
        ovr_clr   = 1'b0;
        chk("ovr_set_wins", overrun, 1);
        wait_idle();

        for (int i = 0; i < N; i++) wg(i, 32);
        send(l0, r0, mixm(l0, gm), mixm(r0, gm));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        gm = '{64, 64, 64, 64};
        #1;
        chk("arst_left", snd_left, 0);
        chk("arst_right", snd_right, 0);
        chk("arst_busy", busy, 0);
        chk("arst_overrun", overrun, 0);
        chk("arst_sample", snd_sample, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        send(l0, r0, mixm(l0, gm), mixm(r0, gm));
        wait_idle();
        chk("post_rst_left", snd_left, 2500);
        chk("post_rst_right", snd_right, -200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jt12_mix_n.md
Name: jt12_mix_n

Overview:
- Parametrised stereo sound mixer; successor to the fixed FM+PSG sum at the chip top level.
- Combines NUM_SRC signed stereo sources (FM, PSG, PCM, extra chips) with per-source programmable gain.
- Sources are snapshotted on a sample strobe and accumulated serially, one source per clock-enable cycle, through a single shared multiplier per side.
- Output is a saturated OUT_W-bit stereo sample with a one-cycle valid pulse.
- Sits between the synthesis cores and the board audio path.

Parameters:
- NUM_SRC, 4, number of stereo sources (2..8).
- IN_W, 16, signed width of each source sample.
- OUT_W, 16, signed width of the mixed output.
- GAIN_W, 8, unsigned gain width. Format Q2.(GAIN_W-2); unity = 2^(GAIN_W-2) = 64.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- cen, in, 1, clock enable; all state advances only when cen=1.
- src_left, in, NUM_SRC*IN_W, packed signed left samples; source i at bits [i*IN_W +: IN_W].
- src_right, in, NUM_SRC*IN_W, packed signed right samples; same packing.
- sample_in, in, 1, new-sample strobe, sampled when cen=1.
- gain_wr, in, 1, gain register write strobe.
- gain_addr, in, 3, source index to write.
- gain_din, in, GAIN_W, gain value.
- busy, out, 1, high while a mix is in progress.
- overrun, out, 1, sticky: a sample_in was dropped.
- ovr_clr, in, 1, clears overrun.
- snd_left, out, OUT_W, mixed left sample (signed).
- snd_right, out, OUT_W, mixed right sample (signed).
- snd_sample, out, 1, one-clk pulse when snd_left/snd_right update.

Behaviour:
- Reset is asynchronous: rst_n=0 forces
  - state IDLE;
  - snd_left, snd_right = 0;
  - snd_sample, busy, overrun = 0;
  - all gains = unity (64);
  - accumulators = 0.
  - Any mix in progress is abandoned; no partial output is produced.
- Gain writes:
  - gain_wr=1 with gain_addr < NUM_SRC updates that gain on the same clk edge; cen is not required.
  - gain_addr >= NUM_SRC is ignored.
- States (advance only on cen=1):
  - IDLE: on sample_in=1, latch all sources plus a shadow copy of all gains, clear both accumulators, set busy=1, index i=0, go to ACC.
  - ACC: acc_l += src_l[i]*gain[i] and acc_r += src_r[i]*gain[i] as signed x unsigned. When i = NUM_SRC-1, go to SAT; otherwise i++.
  - SAT:
    - arithmetic shift right by GAIN_W-2 (truncation toward -infinity);
    - saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1];
    - load snd_left/snd_right;
    - pulse snd_sample for exactly one clk;
    - busy=0; go to IDLE.
- Accumulator width: IN_W+GAIN_W+clog2(NUM_SRC)+1. It never wraps.
- Latency: from the cen cycle that accepts sample_in to the snd_sample pulse is NUM_SRC+2 cen cycles (6 with defaults). No DC blocker in this count.
- Gain writes during ACC do not affect the current mix; they apply to the next sample via the shadow copy.
- sample_in while busy=1 (SAT cycle included) is dropped and sets overrun=1.
- If ovr_clr and a new overrun occur in the same cycle, set wins.
- cen=0: state, index and accumulators hold; snd_sample stays 0.
- Outputs hold their last value between samples.

Optional Feature:
- Macro JT12_MIX_DCBLOCK_EN.
- Defined: adds a per-side first-order DC blocker after SAT:
  - y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1]>>>8), computed at OUT_W+10 bits;
  - result saturated to OUT_W;
  - x and y history reset to 0;
  - latency becomes NUM_SRC+3 cen cycles.
- Undefined: output is the saturated sum; latency NUM_SRC+2; no extra registers.

Test Plan:
- Defaults, all gains 64, L sources {1000,2000,-500,0}, sample_in -> snd_left=2500 exactly 6 cen cycles later; snd_sample high for 1 clk; busy low after.
- All L sources 20000 -> snd_left=32767. All R sources -20000 -> snd_right=-32768.
- gain[1]=32, gain[3]=0, L sources {0,2000,0,7000} -> snd_left=1000. Values -3 with gain 32 -> -2 (floor behaviour).
- sample_in again 2 cen cycles into a mix -> output from the first sample only, overrun=1. ovr_clr -> 0. ovr_clr coincident with a new overrun -> stays 1.
- rst_n low mid-ACC -> immediately snd_left=snd_right=0, busy=0, gains=64, no snd_sample pulse. Next sample mixes correctly.
- cen toggling 1-in-3 -> result identical, latency 6 cen cycles. Gain write during ACC is used only on the following sample.
